bip_loader: RTL

Program loader for the BIP: the write side of the program memory that the control block fetches from. It takes bytes from the UART receiver, decodes a small load/run command protocol, and writes 16-bit instruction words into program memory starting at address 0. It reports ACK/NAK through the UART transmitter and drives `start_bip` to release the processor once a program is in place.

---
 rtl/bip_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bip_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bip_loader
//  Purpose  : Write side of the BIP program memory. Decodes a byte-oriented
//             load/run protocol from the UART receiver and writes 16-bit
//             instruction words from address 0. It replies ACK/NAK through the
//             UART transmitter and releases the processor with start_bip.
//
//  Ports    : clk        system clock, rising edge
//             reset      synchronous, active-low reset
//             rx_done    one-cycle pulse, rx_data valid
//             rx_data    received byte
//             tx_done    transmitter finished the current byte
//             tx_start   one-cycle request to send tx_data
//             tx_data    reply byte, held until the next reply
//             prog_we    program memory write strobe, one cycle per word
//             prog_addr  program memory write address
//             prog_data  instruction word {opcode[4:0], operand[10:0]}
//             start_bip  high while the BIP may run
//             loading    high in every state other than IDLE and RUN
//
//  Revision : 1.0  initial release
// ============================================================================
module bip_loader #(
    parameter int         AB       = 11,
    parameter logic [7:0] CMD_LOAD = 8'h4C,
    parameter logic [7:0] CMD_RUN  = 8'h52
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          tx_done,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          prog_we,
    output logic [AB-1:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic          start_bip,
    output logic          loading
);

    localparam logic [7:0]  C_ACK       = 8'h06;
    localparam logic [7:0]  C_NAK       = 8'h15;
    // Largest legal word count: exactly fills the memory.
    localparam logic [16:0] C_MAX_WORDS = 17'd1 << AB;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CNT_HI   = 4'd1,
        S_CNT_LO   = 4'd2,
        S_W_HI     = 4'd3,
        S_W_LO     = 4'd4,
        S_WRITE    = 4'd5,
        S_ACK      = 4'd6,
        S_ACK_WAIT = 4'd7,
        S_RUN      = 4'd8
    } state_t;

    state_t        r_state;
    logic [7:0]    r_countHi;
    logic [15:0]   r_count;
    // One bit wider than the address so a full-memory load is representable.
    logic [AB:0]   r_index;
    logic [7:0]    r_wordHi;
    logic [7:0]    r_wordLo;
    logic [7:0]    r_reply;

    logic          r_txStart;
    logic [7:0]    r_txData;
    logic          r_progWe;
    logic [AB-1:0] r_progAddr;
    logic [15:0]   r_progData;
    logic          r_startBip;
    logic          r_loading;

    logic [15:0]   w_countNew;
    logic [16:0]   w_countExt;
    logic [16:0]   w_indexNext;
    logic          w_lastWord;

    assign w_countNew  = {r_countHi, rx_data};
    assign w_countExt  = {1'b0, w_countNew};
    assign w_indexNext = 17'(r_index) + 17'd1;
    // The word being written is the last one when index + 1 == N.
    assign w_lastWord  = (w_indexNext == {1'b0, r_count});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_countHi  <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_wordHi   <= '0;
            r_wordLo   <= '0;
            r_reply    <= '0;
            r_txStart  <= 1'b0;
            r_txData   <= '0;
            r_progWe   <= 1'b0;
            r_progAddr <= '0;
            r_progData <= '0;
            r_startBip <= 1'b0;
            r_loading  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            r_txStart <= 1'b0;
            r_progWe  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_done) begin
                        if (rx_data == CMD_LOAD) begin
                            r_state   <= S_CNT_HI;
                            r_loading <= 1'b1;
                        end else if (rx_data == CMD_RUN) begin
                            r_state    <= S_RUN;
                            r_startBip <= 1'b1;
                        end
                    end
                end

                S_CNT_HI: begin
                    if (rx_done) begin
                        r_countHi <= rx_data;
                        r_state   <= S_CNT_LO;
                    end
                end

                S_CNT_LO: begin
                    if (rx_done) begin
                        r_count <= w_countNew;
                        if (w_countExt > C_MAX_WORDS) begin
                            r_reply <= C_NAK;
                            r_state <= S_ACK;
                        end else if (w_countNew == 16'd0) begin
                            r_reply <= C_ACK;
                            r_state <= S_ACK;
                        end else begin
                            r_index <= '0;
                            r_state <= S_W_HI;
                        end
                    end
                end

                S_W_HI: begin
                    if (rx_done) begin
                        r_wordHi <= rx_data;
                        r_state  <= S_W_LO;
                    end
                end

                S_W_LO: begin
                    if (rx_done) begin
                        r_wordLo <= rx_data;
                        r_state  <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    r_progWe   <= 1'b1;
                    r_progAddr <= r_index[AB-1:0];
                    r_progData <= {r_wordHi, r_wordLo};
                    r_index    <= w_indexNext[AB:0];
                    if (w_lastWord) begin
                        r_reply <= C_ACK;
                        r_state <= S_ACK;
                    end else begin
                        r_state <= S_W_HI;
                    end
                end

                S_ACK: begin
                    r_txStart <= 1'b1;
                    r_txData  <= r_reply;
                    r_state   <= S_ACK_WAIT;
                end

                S_ACK_WAIT: begin
                    if (tx_done) begin
                        r_loading <= 1'b0;
                        if (r_reply == C_ACK) begin
                            r_state    <= S_RUN;
                            r_startBip <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_RUN: begin
                    // Halt the BIP in the same transition that begins a reload.
                    if (rx_done && (rx_data == CMD_LOAD)) begin
                        r_state    <= S_CNT_HI;
                        r_startBip <= 1'b0;
                        r_loading  <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_startBip <= 1'b0;
                    r_loading  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start  = r_txStart;
    assign tx_data   = r_txData;
    assign prog_we   = r_progWe;
    assign prog_addr = r_progAddr;
    assign prog_data = r_progData;
    assign start_bip = r_startBip;
    assign loading   = r_loading;

endmodule
`default_nettype wire
